// File: rtl/rob_pkg.sv
// rob_pkg: depth and SN/count types shared by the SN allocator and the ROB control unit
package rob_pkg;
  localparam int ROB_DEPTH = 32;
  localparam int ROB_PTRW = $clog2(ROB_DEPTH);
  typedef logic [ROB_PTRW-1:0] sn_t;
  typedef logic [ROB_PTRW:0] cnt_t;
endpackage

// File: rtl/rob_sn_counter.sv
// rob_sn_counter: wrapping pointer with enable and synchronous reset
module rob_sn_counter #(
  parameter int p_width = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [p_width-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else if (en) q <= q + 1'b1;
  end
endmodule

// File: rtl/rob_sn_alloc.sv
// rob_sn_alloc: in-order SN allocator that blocks reuse until the ROB retires the SN
module rob_sn_alloc
  import rob_pkg::*;
#(
  parameter int p_depth = ROB_DEPTH,
  parameter int p_ptrwidth = $clog2(p_depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_en,
  output logic                  alloc_cpl,
  output logic [p_ptrwidth-1:0] alloc_sn,
  input  logic                  retire_en,
  output logic [p_ptrwidth-1:0] retire_sn,
  output logic [p_ptrwidth:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [p_depth-1:0]    outstanding,
  output logic                  err
);
  localparam logic [p_ptrwidth:0] cnt_full = (p_ptrwidth+1)'(p_depth);
  logic [p_ptrwidth-1:0] alloc_ptr, ret_ptr;
  logic retire_ok;
  rob_sn_counter #(.p_width(p_ptrwidth)) u_alloc_ptr (.clk(clk), .rst(rst), .en(alloc_cpl), .q(alloc_ptr));
  rob_sn_counter #(.p_width(p_ptrwidth)) u_ret_ptr (.clk(clk), .rst(rst), .en(retire_ok), .q(ret_ptr));
  // flags come from registered count only, so a same-cycle retire never reaches alloc_cpl
  always_comb begin
    full = count == cnt_full;
    empty = count == '0;
    alloc_cpl = !rst && alloc_en && !full;
    alloc_sn = rst ? '0 : alloc_ptr;
    retire_ok = retire_en && !empty;
    retire_sn = ret_ptr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      outstanding <= '0;
      err <= 1'b0;
    end else begin
      count <= count + (p_ptrwidth+1)'(alloc_cpl) - (p_ptrwidth+1)'(retire_ok);
      outstanding <= (outstanding | (alloc_cpl ? p_depth'(1) << alloc_ptr : '0))
                     & ~(retire_ok ? p_depth'(1) << ret_ptr : '0);
      err <= err | (retire_en && empty);
    end
  end
endmodule

// File: tb/tb_rob_sn_alloc.sv
// tb_rob_sn_alloc: directed and random checks of rob_sn_alloc against a queue model
module tb_rob_sn_alloc;
  localparam int D = 4;
  localparam int W = 2;
  logic clk = 0, rst = 1, alloc_en = 0, retire_en = 0;
  logic alloc_cpl, full, empty, err;
  logic [W-1:0] alloc_sn, retire_sn;
  logic [W:0] count;
  logic [D-1:0] outstanding;
  int tests = 0, fails = 0;
  int q[$];
  int nsn = 0;
  bit merr = 0, live = 0, fire, rok;
  logic [D-1:0] exp_out;

  rob_sn_alloc #(.p_depth(D)) dut (
    .clk(clk), .rst(rst), .alloc_en(alloc_en), .alloc_cpl(alloc_cpl), .alloc_sn(alloc_sn),
    .retire_en(retire_en), .retire_sn(retire_sn), .count(count), .full(full), .empty(empty),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: FIFO of in-flight SNs, next SN to grant, sticky error
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      nsn = 0;
      merr = 0;
      live = 1;
    end else begin
      fire = alloc_en && q.size() < D;
      rok = retire_en && q.size() > 0;
      if (retire_en && q.size() == 0) merr = 1;
      if (rok) void'(q.pop_front());
      if (fire) begin
        q.push_back(nsn);
        nsn = (nsn + 1) % D;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      exp_out = '0;
      foreach (q[i]) exp_out[q[i]] = 1'b1;
      chk("alloc_cpl", alloc_cpl, !rst && alloc_en && q.size() < D);
      chk("alloc_sn", alloc_sn, rst ? 0 : nsn);
      chk("count", count, q.size());
      chk("full", full, q.size() == D);
      chk("empty", empty, q.size() == 0);
      chk("retire_sn", retire_sn, q.size() > 0 ? q[0] : nsn);
      chk("outstanding", outstanding, exp_out);
      chk("err", err, merr);
      if (alloc_cpl) chk("sn_reuse", outstanding[alloc_sn], 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    step();
    alloc_en = 1;
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      chk("fill_cpl", alloc_cpl, 1);
      chk("fill_sn", alloc_sn, i);
      step();
    end
    retire_en = 1;
    @(negedge clk);
    chk("full_flag", full, 1);
    chk("full_count", count, 4);
    chk("full_out", outstanding, 4'b1111);
    chk("full_block", alloc_cpl, 0);
    step();
    retire_en = 0;
    @(negedge clk);
    chk("unblk_count", count, 3);
    chk("unblk_rsn", retire_sn, 1);
    chk("unblk_full", full, 0);
    chk("unblk_cpl", alloc_cpl, 1);
    chk("unblk_sn", alloc_sn, 0);
    step();
    alloc_en = 0;
    retire_en = 1;
    repeat (2) step();
    alloc_en = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("ss_count", count, 2);
      chk("ss_sn", alloc_sn, (1 + k) % D);
      step();
    end
    alloc_en = 0;
    repeat (2) step();
    rst = 1;
    retire_en = 0;
    step();
    rst = 0;
    retire_en = 1;
    step();
    retire_en = 0;
    @(negedge clk);
    chk("uf_count", count, 0);
    chk("uf_rsn", retire_sn, 0);
    chk("uf_err", err, 1);
    repeat (5) step();
    chk("uf_err_sticky", err, 1);
    alloc_en = 1;
    repeat (3) step();
    alloc_en = 1;
    rst = 1;
    @(negedge clk);
    chk("mid_rst_cpl", alloc_cpl, 0);
    chk("mid_rst_sn", alloc_sn, 0);
    step();
    rst = 0;
    @(negedge clk);
    chk("post_count", count, 0);
    chk("post_empty", empty, 1);
    chk("post_err", err, 0);
    chk("post_sn", alloc_sn, 0);
    chk("post_cpl", alloc_cpl, 1);
    step();
    for (int k = 0; k < 2000; k++) begin
      alloc_en = $urandom_range(0, 99) < 55;
      retire_en = q.size() > 0 && $urandom_range(0, 99) < 50;
      step();
    end
    alloc_en = 0;
    retire_en = 0;
    @(negedge clk);
    chk("rand_err", err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
